// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM; MCTRL_INSTRET_EN adds the retired-instruction counter.
// 3-5 cycles per instruction, plus one per mem_ready wait; FETCH/MEMRD/MEMWR hold until mem_ready.
module multicycle_ctrl #(
  parameter int OPC_W = 7,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic [2:0]       imm_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             reg_write,
  output logic             illegal,
`ifdef MCTRL_INSTRET_EN
  output logic [CNT_W-1:0] instret,
`endif
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
    S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXECR = 4'd7,
    S_EXECI = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
    S_JALRA = 4'd12, S_UPPER = 4'd13, S_TRAP = 4'd14
  } state_t;

  localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(7'b0100011);
  localparam logic [OPC_W-1:0] OP_ALUR  = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] OP_ALUI  = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] OP_BR    = OPC_W'(7'b1100011);
  localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(7'b1101111);
  localparam logic [OPC_W-1:0] OP_JALR  = OPC_W'(7'b1100111);
  localparam logic [OPC_W-1:0] OP_LUI   = OPC_W'(7'b0110111);
  localparam logic [OPC_W-1:0] OP_AUIPC = OPC_W'(7'b0010111);

  state_t state;
  logic   is_store;
  logic   is_lui;

  function automatic state_t dec_next(input logic [OPC_W-1:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEMADR;
      OP_ALUR:           return S_EXECR;
      OP_ALUI:           return S_EXECI;
      OP_BR:             return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALRA;
      OP_LUI, OP_AUIPC:  return S_UPPER;
      default:           return S_TRAP;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_STORE:         return 3'd1;
      OP_BR:            return 3'd2;
      OP_JAL:           return 3'd3;
      OP_LUI, OP_AUIPC: return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  // Load/store and lui/auipc flavours are captured at DECODE so later states do not depend on IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      imm_src  <= 3'd0;
      is_store <= 1'b0;
      is_lui   <= 1'b0;
    end else begin
      case (state)
        S_RST:    state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          imm_src  <= imm_of(opcode);
          is_store <= (opcode == OP_STORE);
          is_lui   <= (opcode == OP_LUI);
          state    <= dec_next(opcode);
        end
        S_MEMADR: state <= is_store ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
        S_EXECR, S_EXECI, S_UPPER:  state <= S_ALUWB;
        S_JAL:    state <= S_ALUWB;
        S_JALRA:  state <= S_JAL;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_RST;
      endcase
    end
  end

`ifdef MCTRL_INSTRET_EN
  logic retire;
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                  ((state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
`endif

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEMADR, S_JALRA: begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMRD: begin mem_req = 1'b1; adr_src = 1'b1; end
      S_MEMWB: begin result_src = 2'b01; reg_write = 1'b1; end
      S_MEMWR: begin mem_req = 1'b1; mem_we = 1'b1; adr_src = 1'b1; end
      S_EXECR: begin alu_src_a = 2'b10; alu_op = 2'b10; end
      S_EXECI: begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin alu_src_a = 2'b10; alu_op = 2'b01; pc_write = br_taken; end
      S_JAL: begin pc_write = 1'b1; alu_src_a = 2'b01; alu_src_b = 2'b10; end
      S_UPPER: begin alu_src_a = is_lui ? 2'b11 : 2'b01; alu_src_b = 2'b01; end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level route/latency model.
module tb_multicycle_ctrl;

  localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3, ST_MEMRD = 4,
                 ST_MEMWB = 5, ST_MEMWR = 6, ST_EXECR = 7, ST_EXECI = 8, ST_ALUWB = 9,
                 ST_BRANCH = 10, ST_JAL = 11, ST_JALRA = 12, ST_UPPER = 13, ST_TRAP = 14;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_ALUR = 7'b0110011,
                         OP_ALUI = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state_o;
`ifdef MCTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  multicycle_ctrl #(.OPC_W(7), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .reg_write(reg_write), .illegal(illegal),
`ifdef MCTRL_INSTRET_EN
    .instret(instret),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_steps = 0;
  logic [2:0]  exp_imm = 3'd0;
  bit          exp_lui = 1'b0;
  logic [31:0] exp_instret = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Spec table of output values per state, packed in the same order as the observed bundle.
  function automatic logic [17:0] exp_vec(input int st, input bit mr, input bit bt);
    logic req, we, adr, irw, pcw, rw, ill;
    logic [1:0] a, b, op, res;
    {req, we, adr, irw, pcw, rw, ill} = '0;
    {a, b, op, res} = '0;
    case (st)
      ST_FETCH:  begin req = 1; b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      ST_DECODE: begin a = 2'b01; b = 2'b01; end
      ST_MEMADR: begin a = 2'b10; b = 2'b01; end
      ST_MEMRD:  begin req = 1; adr = 1; end
      ST_MEMWB:  begin res = 2'b01; rw = 1; end
      ST_MEMWR:  begin req = 1; we = 1; adr = 1; end
      ST_EXECR:  begin a = 2'b10; b = 2'b00; op = 2'b10; end
      ST_EXECI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      ST_ALUWB:  begin res = 2'b00; rw = 1; end
      ST_BRANCH: begin a = 2'b10; op = 2'b01; pcw = bt; end
      ST_JAL:    begin pcw = 1; a = 2'b01; b = 2'b10; end
      ST_JALRA:  begin a = 2'b10; b = 2'b01; end
      ST_UPPER:  begin a = exp_lui ? 2'b11 : 2'b01; b = 2'b01; end
      ST_TRAP:   ill = 1;
      default: ;
    endcase
    return {req, we, adr, irw, pcw, exp_imm, a, b, op, res, rw, ill};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == OP_LOAD || op == OP_ALUI || op == OP_JALR) return 3'd0;
    if (op == OP_STORE) return 3'd1;
    if (op == OP_BR)    return 3'd2;
    if (op == OP_JAL)   return 3'd3;
    if (op == OP_LUI || op == OP_AUIPC) return 3'd4;
    return 3'd0;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, well before the rising edge.
  task automatic step(input int st, input bit mr, input bit bt, input bit rn = 1'b1);
    @(negedge clk);
    mem_ready = mr;
    br_taken  = bt;
    rst_n     = rn;
    #1;
    n_steps++;
    check("state", 32'(state_o), 32'(st));
    check("outs", 32'({mem_req, mem_we, adr_src, ir_write, pc_write, imm_src, alu_src_a,
                       alu_src_b, alu_op, result_src, reg_write, illegal}),
          32'(exp_vec(st, mr, bt)));
`ifdef MCTRL_INSTRET_EN
    check("instret", instret, exp_instret);
`endif
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int n_low);
    exp_imm = 3'd0;
    exp_instret = 32'd0;
    for (int i = 0; i < n_low; i++) step(ST_RST, rb(), rb(), 1'b0);
    step(ST_RST, rb(), rb(), 1'b1);
  endtask

  // wf/wm: FETCH and memory wait cycles (-1 = random); btv: branch outcome (-1 = random).
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input int btv);
    int w_f, w_m, base, start;
    bit bt;
    w_f = (wf < 0) ? int'($urandom_range(0, 2)) : wf;
    w_m = (wm < 0) ? int'($urandom_range(0, 2)) : wm;
    bt  = (btv < 0) ? rb() : btv[0];
    start = n_steps;
    opcode = op;
    for (int i = 0; i < w_f; i++) step(ST_FETCH, 1'b0, rb());
    step(ST_FETCH, 1'b1, rb());
    step(ST_DECODE, rb(), rb());
    exp_imm = imm_of(op);
    exp_lui = (op == OP_LUI);
    base = 4;
    case (op)
      OP_LOAD: begin
        base = 5;
        step(ST_MEMADR, rb(), rb());
        for (int i = 0; i < w_m; i++) step(ST_MEMRD, 1'b0, rb());
        step(ST_MEMRD, 1'b1, rb());
        step(ST_MEMWB, rb(), rb());
      end
      OP_STORE: begin
        step(ST_MEMADR, rb(), rb());
        for (int i = 0; i < w_m; i++) step(ST_MEMWR, 1'b0, rb());
        step(ST_MEMWR, 1'b1, rb());
      end
      OP_ALUR: begin step(ST_EXECR, rb(), rb()); step(ST_ALUWB, rb(), rb()); end
      OP_ALUI: begin step(ST_EXECI, rb(), rb()); step(ST_ALUWB, rb(), rb()); end
      OP_BR:   begin base = 3; step(ST_BRANCH, rb(), bt); end
      OP_JAL:  begin step(ST_JAL, rb(), rb()); step(ST_ALUWB, rb(), rb()); end
      OP_JALR: begin
        base = 5;
        step(ST_JALRA, rb(), rb()); step(ST_JAL, rb(), rb()); step(ST_ALUWB, rb(), rb());
      end
      default: begin step(ST_UPPER, rb(), rb()); step(ST_ALUWB, rb(), rb()); end
    endcase
    exp_instret = exp_instret + 32'd1;
    if (op != OP_LOAD && op != OP_STORE) w_m = 0;
    check("latency", 32'(n_steps - start), 32'(base + w_f + w_m));
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{OP_LOAD, OP_STORE, OP_ALUR, OP_ALUI, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    do_reset(3);

    // Directed sequence: add, load with 2 waits, store, beq taken / not taken, jumps, uppers.
    run_instr(OP_ALUR, 0, 0, 0);
    run_instr(OP_LOAD, 0, 2, 0);
    run_instr(OP_BR, 0, 0, 1);
    check("instret_seq", 32'(exp_instret), 32'd3);
    run_instr(OP_STORE, 1, 1, 0);
    run_instr(OP_BR, 0, 0, 0);
    run_instr(OP_JAL, 0, 0, 0);
    run_instr(OP_JALR, 0, 0, 0);
    run_instr(OP_LUI, 0, 0, 0);
    run_instr(OP_AUIPC, 0, 0, 0);

    for (int n = 0; n < 300; n++) run_instr(ops[$urandom_range(0, 8)], -1, -1, -1);

    // Abort a load while its memory request is pending.
    opcode = OP_LOAD;
    step(ST_FETCH, 1'b1, 1'b0);
    step(ST_DECODE, 1'b0, 1'b0);
    exp_imm = 3'd0;
    step(ST_MEMADR, 1'b0, 1'b0);
    step(ST_MEMRD, 1'b0, 1'b0);
    do_reset(2);
    run_instr(OP_ALUI, -1, -1, -1);

    // Illegal opcode parks in TRAP; mem_ready and br_taken must not disturb it.
    opcode = 7'b1111111;
    step(ST_FETCH, 1'b1, 1'b0);
    step(ST_DECODE, 1'b1, 1'b1);
    exp_imm = 3'd0;
    for (int i = 0; i < 6; i++) step(ST_TRAP, rb(), rb());
    do_reset(1);
    for (int n = 0; n < 20; n++) run_instr(ops[$urandom_range(0, 8)], -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

endmodule
